stack_controller: RTL and testbench
===================================

// Module: stack_controller
// PURPOSE
//  Sequences the calculator's stack datapath: takes the one-cycle command code from the button
//  decoder and drives a single-port synchronous stack RAM through read/modify/write steps.
//  Owns the stack pointer, the displayed top-of-stack value and the status flags.
//  Sits between the button decoder and the stack RAM/display drivers.
// PARAMETERS
//  DATA_W  8  width of a stack entry, iData and oTop
//  ADDR_W  7  RAM address width; localparam DEPTH = 2**ADDR_W entries
// PORTS
//  iClk     in   1         system clock; all state changes on rising edge
//  iRst     in   1         reset, asynchronous, active-high
//  iCmd     in   4         command code: 0 idle, 1 PSH, 2 POP, 3 ADD, 4 SUB, 5 TOP, 6 RST, 7 INC, 8 DEC
//  iData    in   DATA_W    operand for PSH (switches)
//  iRdData  in   DATA_W    RAM read data, valid the cycle after oAddr is presented with oWe=0
//  oAddr    out  ADDR_W    RAM address
//  oWrData  out  DATA_W    RAM write data
//  oWe      out  1         RAM write enable; write occurs on the edge ending the cycle
//  oTop     out  DATA_W    value of the top entry; 0 when empty
//  oSP      out  ADDR_W+1  entry count 0..DEPTH; top entry at address oSP-1
//  oEmpty   out  1         oSP==0 (combinational from oSP)
//  oFull    out  1         oSP==DEPTH (combinational from oSP)
//  oBusy    out  1         high while FSM is not in S_IDLE
//  oErr     out  1         sticky underflow/overflow flag
// BEHAVIOUR
//  Reset: state S_IDLE, oSP=0, oTop=0, oErr=0, oWe=0, oAddr=0, oWrData=0. Reset mid-operation
//   aborts immediately: oWe deasserts asynchronously; no partial write.
//  iCmd is sampled only in S_IDLE. Nonzero codes in other states are dropped silently (no oErr).
//   Codes 9..15 are treated as idle.
//  FSM states: S_IDLE, S_RDA, S_RDB, S_LATB, S_WR, S_RDT, S_LATT.
//  PSH: full -> oErr=1, no change. Otherwise S_WR: oWe=1, oAddr=oSP, oWrData=iData captured at accept;
//   oSP+=1, oTop=iData. Then S_IDLE. oTop valid 2 edges after the accept edge.
//  POP: oSP<2 -> oSP-1 is 0 or error. Empty -> oErr=1, no change. Otherwise oSP-=1 at accept.
//   New oSP==0 -> oTop=0, back to S_IDLE. Else S_RDT (addr oSP-1), then S_LATT (oTop<=iRdData), then S_IDLE.
//  ADD/SUB: oSP<2 -> oErr=1, no change. Otherwise:
//   S_RDA: addr oSP-1.
//   S_RDB: addr oSP-2; A<=iRdData.
//   S_LATB: B<=iRdData.
//   S_WR: write at oSP-2; ADD=B+A, SUB=B-A, modulo 2**DATA_W; oSP-=1; oTop=result.
//  INC/DEC: empty -> oErr=1. Otherwise S_RDA (addr oSP-1), then S_LATB (A<=iRdData).
//   S_WR writes A+1 or A-1 at oSP-1 (mod 2**DATA_W); oTop=result; oSP unchanged.
//  TOP: empty -> oTop=0, no error. Otherwise S_RDT, then S_LATT (refreshes oTop from RAM).
//  RST: single cycle in S_IDLE: oSP=0, oTop=0, oErr=0. RAM is not cleared.
//  Error clears only by RST or iRst. An erroring command never writes RAM and never moves oSP.
//  oWe is asserted only in S_WR. oAddr and oWrData are registered.
// CONFIGURATION
//  `STACK_CTRL_SAT_EN defined: ADD, SUB, INC and DEC saturate to 2**DATA_W-1 or 0.
//   Saturation sets oErr.
//  Not defined: arithmetic wraps modulo 2**DATA_W; overflow never sets oErr.
// STRUCTURE
//  stack_defs.vh, shared with the button decoder: command codes (ST_IDLE..ST_DEC), FSM state
//   encodings, and the ALU op select encoding.
//  Sub-module stack_alu: combinational; inputs A, B, op; outputs result and ovf.
//   Holds the `STACK_CTRL_SAT_EN logic.
//  stack_controller: FSM, SP register, operand latches, RAM port drive.
// TESTING (bench models 128x8 sync RAM)
//  1. iRst; PSH 0x05; PSH 0x03 -> mem[0]=05, mem[1]=03, oSP=2, oTop=0x03, oErr=0.
//  2. From test 1, SUB -> one write, oAddr=0, oWrData=0x02; oSP=1, oTop=0x02, oBusy low after 4 cycles.
//  3. From reset, POP and ADD -> oErr=1, oSP=0, oWe never high. Then RST -> oErr=0.
//  4. 128 PSH of i -> oFull=1. 129th PSH -> oErr=1, no write. POP -> oSP=127, oTop=126.
//  5. PSH 0x00, DEC -> oTop=0xFF (wrap), or 0x00 with oErr=1 under `STACK_CTRL_SAT_EN.
//     PSH 0xF0, PSH 0x20, ADD -> 0x10 (wrap), or 0xFF under `STACK_CTRL_SAT_EN.
//  6. PSH pulsed while oBusy=1 -> ignored. iRst asserted during S_WR of ADD -> oWe=0 same cycle;
//     oSP=0 and oTop=0 afterwards.

Source files
------------

// File: rtl/stack_controller_pkg.sv
// Shared encodings for the calculator stack: command codes, controller FSM states, ALU op select.
package stack_controller_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_PSH  = 4'd1,
    ST_POP  = 4'd2,
    ST_ADD  = 4'd3,
    ST_SUB  = 4'd4,
    ST_TOP  = 4'd5,
    ST_RST  = 4'd6,
    ST_INC  = 4'd7,
    ST_DEC  = 4'd8
  } cmd_e;

  typedef enum logic [2:0] {
    S_IDLE, S_RDA, S_RDB, S_LATB, S_WR, S_RDT, S_LATT
  } state_e;

  typedef enum logic [1:0] {
    ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC
  } alu_op_e;

  function automatic alu_op_e cmd_to_alu(input logic [3:0] cmd);
    case (cmd)
      ST_SUB:  return ALU_SUB;
      ST_INC:  return ALU_INC;
      ST_DEC:  return ALU_DEC;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/stack_controller_alu.sv
// Combinational stack ALU (B+A, B-A, A+1, A-1). With `STACK_CTRL_SAT_EN results clamp to
// all-ones/zero and ovf flags the clamp; otherwise results wrap and ovf stays low.
module stack_alu
  import stack_controller_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] result,
  output logic              ovf
);

  // Extra MSB carries the add carry-out or the subtract borrow.
  logic [DATA_W:0] sum;

  always_comb begin
    sum = '0;
    case (op)
      ALU_ADD: sum = {1'b0, b} + {1'b0, a};
      ALU_SUB: sum = {1'b0, b} - {1'b0, a};
      ALU_INC: sum = {1'b0, a} + (DATA_W+1)'(1);
      ALU_DEC: sum = {1'b0, a} - (DATA_W+1)'(1);
      default: sum = '0;
    endcase
  end

`ifdef STACK_CTRL_SAT_EN
  always_comb begin
    ovf    = sum[DATA_W];
    result = sum[DATA_W-1:0];
    if (ovf) result = (op == ALU_ADD || op == ALU_INC) ? '1 : '0;
  end
`else
  logic carry_unused;
  assign carry_unused = sum[DATA_W];
  assign ovf          = 1'b0;
  assign result       = sum[DATA_W-1:0];
`endif

endmodule

// File: rtl/stack_controller.sv
// Stack sequencer: FSM driving a single-port sync stack RAM, owning SP, displayed top and sticky error.
// Arithmetic saturation is selected by `STACK_CTRL_SAT_EN (see stack_alu).
module stack_controller
  import stack_controller_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 7
) (
  input  logic              iClk,
  input  logic              iRst,
  input  logic [3:0]        iCmd,
  input  logic [DATA_W-1:0] iData,
  input  logic [DATA_W-1:0] iRdData,
  output logic [ADDR_W-1:0] oAddr,
  output logic [DATA_W-1:0] oWrData,
  output logic              oWe,
  output logic [DATA_W-1:0] oTop,
  output logic [ADDR_W:0]   oSP,
  output logic              oEmpty,
  output logic              oFull,
  output logic              oBusy,
  output logic              oErr
);

  localparam int DEPTH = 2**ADDR_W;

  state_e              state_q, state_d;
  logic [ADDR_W:0]     sp_q, sp_d;
  logic [DATA_W-1:0]   top_q, top_d;
  logic                err_q, err_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wr_q, wr_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [3:0]          op_q, op_d;

  logic [ADDR_W-1:0]   sp_m1, sp_m2;
  logic                empty, full, unary;
  logic [DATA_W-1:0]   alu_a, alu_res;
  logic                alu_ovf;

  assign sp_m1 = sp_q[ADDR_W-1:0] - ADDR_W'(1);
  assign sp_m2 = sp_q[ADDR_W-1:0] - ADDR_W'(2);
  assign empty = (sp_q == '0);
  assign full  = (sp_q == (ADDR_W+1)'(DEPTH));
  assign unary = (op_q == ST_INC) || (op_q == ST_DEC);

  // The second operand is used straight off the RAM port in S_LATB so the write can start next cycle.
  assign alu_a = unary ? iRdData : a_q;

  stack_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (alu_a),
    .b      (iRdData),
    .op     (cmd_to_alu(op_q)),
    .result (alu_res),
    .ovf    (alu_ovf)
  );

  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    top_d   = top_q;
    err_d   = err_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wr_d    = wr_q;
    a_d     = a_q;
    op_d    = op_q;
    case (state_q)
      S_IDLE: begin
        op_d = iCmd;
        case (iCmd)
          ST_PSH: begin
            if (full) err_d = 1'b1;
            else begin
              state_d = S_WR;
              we_d    = 1'b1;
              addr_d  = sp_q[ADDR_W-1:0];
              wr_d    = iData;
            end
          end
          ST_POP: begin
            if (empty) err_d = 1'b1;
            else begin
              sp_d = sp_q - (ADDR_W+1)'(1);
              if (sp_q == (ADDR_W+1)'(1)) top_d = '0;
              else begin
                state_d = S_RDT;
                addr_d  = sp_m2;
              end
            end
          end
          ST_ADD, ST_SUB: begin
            if (sp_q < (ADDR_W+1)'(2)) err_d = 1'b1;
            else begin
              state_d = S_RDA;
              addr_d  = sp_m1;
            end
          end
          ST_INC, ST_DEC: begin
            if (empty) err_d = 1'b1;
            else begin
              state_d = S_RDA;
              addr_d  = sp_m1;
            end
          end
          ST_TOP: begin
            if (empty) top_d = '0;
            else begin
              state_d = S_RDT;
              addr_d  = sp_m1;
            end
          end
          ST_RST: begin
            sp_d  = '0;
            top_d = '0;
            err_d = 1'b0;
          end
          default: ;
        endcase
      end
      S_RDA: begin
        if (unary) state_d = S_LATB;
        else begin
          state_d = S_RDB;
          addr_d  = sp_m2;
        end
      end
      S_RDB: begin
        a_d     = iRdData;
        state_d = S_LATB;
      end
      S_LATB: begin
        state_d = S_WR;
        we_d    = 1'b1;
        wr_d    = alu_res;
        addr_d  = unary ? sp_m1 : sp_m2;
        if (alu_ovf) err_d = 1'b1;
      end
      S_WR: begin
        state_d = S_IDLE;
        top_d   = wr_q;
        if (op_q == ST_PSH) sp_d = sp_q + (ADDR_W+1)'(1);
        else if (!unary)    sp_d = sp_q - (ADDR_W+1)'(1);
      end
      S_RDT:  state_d = S_LATT;
      S_LATT: begin
        top_d   = iRdData;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      top_q   <= '0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wr_q    <= '0;
      a_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      top_q   <= top_d;
      err_q   <= err_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      a_q     <= a_d;
      op_q    <= op_d;
    end
  end

  assign oAddr   = addr_q;
  assign oWrData = wr_q;
  assign oWe     = we_q;
  assign oTop    = top_q;
  assign oSP     = sp_q;
  assign oEmpty  = empty;
  assign oFull   = full;
  assign oBusy   = (state_q != S_IDLE);
  assign oErr    = err_q;

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: 128x8 sync RAM model plus a queue-based stack reference model.
module tb_stack_controller;

  localparam int DEPTH = 128;

  logic       iClk = 1'b0;
  logic       iRst;
  logic [3:0] iCmd;
  logic [7:0] iData;
  logic [7:0] iRdData;
  logic [6:0] oAddr;
  logic [7:0] oWrData;
  logic       oWe;
  logic [7:0] oTop;
  logic [7:0] oSP;
  logic       oEmpty, oFull, oBusy, oErr;

  stack_controller dut (
    .iClk(iClk), .iRst(iRst), .iCmd(iCmd), .iData(iData), .iRdData(iRdData),
    .oAddr(oAddr), .oWrData(oWrData), .oWe(oWe), .oTop(oTop), .oSP(oSP),
    .oEmpty(oEmpty), .oFull(oFull), .oBusy(oBusy), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  logic [7:0] mem [DEPTH];
  int wr_cnt = 0;

  always @(posedge iClk) begin
    if (oWe) begin
      mem[oAddr] <= oWrData;
      wr_cnt     <= wr_cnt + 1;
    end
    iRdData <= mem[oAddr];
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: the stack is a queue, index 0 = bottom.
  logic [7:0] q[$];
  bit m_err = 1'b0;

  function automatic logic [7:0] m_top();
    return (q.size() != 0) ? q[q.size()-1] : 8'h00;
  endfunction

  function automatic int clamp(input int r);
`ifdef STACK_CTRL_SAT_EN
    if (r > 255) begin m_err = 1'b1; return 255; end
    if (r < 0)   begin m_err = 1'b1; return 0; end
`endif
    return r & 255;
  endfunction

  task automatic model(input logic [3:0] c, input logic [7:0] d, output int ewr, output int ebusy);
    int a, b, r;
    ewr = 0; ebusy = 0;
    case (c)
      4'd1: if (q.size() == DEPTH) m_err = 1'b1;
            else begin q.push_back(d); ewr = 1; ebusy = 1; end
      4'd2: if (q.size() == 0) m_err = 1'b1;
            else begin void'(q.pop_back()); ebusy = (q.size() != 0) ? 2 : 0; end
      4'd3, 4'd4: if (q.size() < 2) m_err = 1'b1;
            else begin
              a = int'(q.pop_back()); b = int'(q.pop_back());
              r = clamp((c == 4'd3) ? b + a : b - a);
              q.push_back(8'(r)); ewr = 1; ebusy = 4;
            end
      4'd7, 4'd8: if (q.size() == 0) m_err = 1'b1;
            else begin
              a = int'(q.pop_back());
              r = clamp((c == 4'd7) ? a + 1 : a - 1);
              q.push_back(8'(r)); ewr = 1; ebusy = 3;
            end
      4'd5: ebusy = (q.size() != 0) ? 2 : 0;
      4'd6: begin q.delete(); m_err = 1'b0; end
      default: ;
    endcase
  endtask

  task automatic check_state(input string tag);
    check({tag, "_sp"}, 32'(oSP), 32'(q.size()));
    check({tag, "_top"}, 32'(oTop), 32'(m_top()));
    check({tag, "_err"}, 32'(oErr), 32'(m_err));
    check({tag, "_empty"}, 32'(oEmpty), 32'(q.size() == 0));
    check({tag, "_full"}, 32'(oFull), 32'(q.size() == DEPTH));
    if (q.size() != 0) check({tag, "_mem"}, 32'(mem[q.size()-1]), 32'(m_top()));
  endtask

  task automatic do_cmd(input logic [3:0] c, input logic [7:0] d, output int bc, output int nw);
    int w0;
    w0 = wr_cnt;
    @(negedge iClk); iCmd = c; iData = d;
    @(negedge iClk); iCmd = 4'd0; iData = 8'($urandom);
    bc = 0;
    while (oBusy && bc < 20) begin
      bc++;
      @(negedge iClk);
    end
    nw = wr_cnt - w0;
  endtask

  task automatic step(input string tag, input logic [3:0] c, input logic [7:0] d);
    int bc, nw, ewr, eb;
    do_cmd(c, d, bc, nw);
    model(c, d, ewr, eb);
    check({tag, "_busy"}, 32'(bc), 32'(eb));
    check({tag, "_writes"}, 32'(nw), 32'(ewr));
    check_state(tag);
  endtask

  initial begin
    int k, w0, bc, nw, ewr, eb;
    logic [3:0] c;
    iRst = 1'b1; iCmd = 4'd0; iData = 8'd0;
    repeat (2) @(negedge iClk);
    check("rst_sp", 32'(oSP), 32'd0);
    check("rst_top", 32'(oTop), 32'd0);
    check("rst_err", 32'(oErr), 32'd0);
    check("rst_we", 32'(oWe), 32'd0);
    check("rst_addr", 32'(oAddr), 32'd0);
    check("rst_wrdat", 32'(oWrData), 32'd0);
    check("rst_busy", 32'(oBusy), 32'd0);
    iRst = 1'b0;
    @(negedge iClk);

    // Two pushes then SUB: 5 - 3 written at address 0
    step("psh5", 4'd1, 8'h05);
    step("psh3", 4'd1, 8'h03);
    check("t1_mem0", 32'(mem[0]), 32'h05);
    check("t1_mem1", 32'(mem[1]), 32'h03);
    do_cmd(4'd4, 8'h00, bc, nw);
    model(4'd4, 8'h00, ewr, eb);
    check("sub_busy", 32'(bc), 32'd4);
    check("sub_writes", 32'(nw), 32'd1);
    check("sub_addr", 32'(oAddr), 32'd0);
    check("sub_wrdat", 32'(oWrData), 32'h02);
    check("sub_top", 32'(oTop), 32'h02);
    check_state("sub");

    // Underflow from empty, then RST clears the error
    step("pop1", 4'd2, 8'h00);
    step("pop_empty", 4'd2, 8'h00);
    step("add_empty", 4'd3, 8'h00);
    check("uf_err", 32'(oErr), 32'd1);
    step("inc_empty", 4'd7, 8'h00);
    step("rst_cmd", 4'd6, 8'h00);
    check("rst_cmd_err", 32'(oErr), 32'd0);

    // Fill to capacity, overflow, then pop
    for (int i = 0; i < DEPTH; i++) step("fill", 4'd1, 8'(i));
    check("full_flag", 32'(oFull), 32'd1);
    step("psh_over", 4'd1, 8'hAA);
    check("over_err", 32'(oErr), 32'd1);
    step("pop_full", 4'd2, 8'h00);
    check("pop_full_sp", 32'(oSP), 32'd127);
    check("pop_full_top", 32'(oTop), 32'd126);
    step("top_cmd", 4'd5, 8'h00);
    step("rst2", 4'd6, 8'h00);

    // Arithmetic boundaries
    step("psh0", 4'd1, 8'h00);
    step("dec0", 4'd8, 8'h00);
`ifdef STACK_CTRL_SAT_EN
    check("dec0_val", 32'(oTop), 32'h00);
    check("dec0_err", 32'(oErr), 32'd1);
`else
    check("dec0_val", 32'(oTop), 32'hFF);
    check("dec0_err", 32'(oErr), 32'd0);
`endif
    step("pshF0", 4'd1, 8'hF0);
    step("psh20", 4'd1, 8'h20);
    step("add_ovf", 4'd3, 8'h00);
`ifdef STACK_CTRL_SAT_EN
    check("add_ovf_val", 32'(oTop), 32'hFF);
`else
    check("add_ovf_val", 32'(oTop), 32'h10);
`endif
    step("top_empty_chk", 4'd5, 8'h00);

    // PSH pulsed while busy is dropped
    step("psh11", 4'd1, 8'h11);
    w0 = wr_cnt;
    @(negedge iClk); iCmd = 4'd3;
    @(negedge iClk); iCmd = 4'd1; iData = 8'h77;
    @(negedge iClk); iCmd = 4'd0;
    k = 0;
    while (oBusy && k < 20) begin k++; @(negedge iClk); end
    model(4'd3, 8'h00, ewr, eb);
    check("busy_drop_writes", 32'(wr_cnt - w0), 32'd1);
    check_state("busy_drop");

    // Reset during the write cycle of ADD
    step("psh_a", 4'd1, 8'h21);
    @(negedge iClk); iCmd = 4'd3;
    @(negedge iClk); iCmd = 4'd0;
    k = 0;
    while (!oWe && k < 20) begin k++; @(negedge iClk); end
    check("midrst_we_seen", 32'(oWe), 32'd1);
    w0 = wr_cnt;
    iRst = 1'b1;
    #1;
    check("midrst_we", 32'(oWe), 32'd0);
    check("midrst_sp", 32'(oSP), 32'd0);
    check("midrst_top", 32'(oTop), 32'd0);
    @(negedge iClk);
    iRst = 1'b0;
    check("midrst_nowrite", 32'(wr_cnt - w0), 32'd0);
    q.delete(); m_err = 1'b0;
    @(negedge iClk);

    // Randomized command stream against the reference model
    for (int i = 0; i < 250; i++) begin
      c = 4'($urandom_range(0, 15));
      if (c == 4'd6 && $urandom_range(0, 3) != 0) c = 4'd1;
      if (c > 4'd8 && $urandom_range(0, 1) != 0) c = 4'd1;
      step("rnd", c, 8'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
